regfile_wb_queue: RTL and testbench

- Write-side producer for the 3-port register file (32 x 32-bit, register $0 hard-wired to zero, write port we3/wa3/wd3, write committed on rising clk).
- Accepts write-back requests from execute/memory units over a valid/ready handshake and buffers them in a small FIFO.
- Drains one write per cycle into the register file's write port.
- Exports a per-register pending bitmask so the decode stage can detect read-after-write hazards against queued writes.

---
 rtl/regfile_wb_queue.sv | 80 ++++++++
 tb/tb_regfile_wb_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file write port (we3/wa3/wd3).
// Buffers accepted requests in a FIFO and exports a pending mask for hazard checks.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [AW-1:0]              req_addr,
    input  logic [DW-1:0]              req_data,
    input  logic                       wb_stall,
    output logic                       we3,
    output logic [AW-1:0]              wa3,
    output logic [DW-1:0]              wd3,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    assign req_ready = (count != CW'(DEPTH));
    // Writes to $0 complete the handshake but are dropped here.
    assign push      = req_valid & req_ready & (req_addr != '0);
    assign we3       = (count != '0) & ~wb_stall;
    assign pop       = we3;
    assign wa3       = (count != '0) ? addr_mem[rd_ptr] : '0;
    assign wd3       = (count != '0) ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= req_addr;
            data_mem[wr_ptr] <= req_data;
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offs;
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < count) begin
                for (int unsigned r = 1; r < 32; r++) begin
                    if (addr_mem[i] == AW'(r))
                        pending[r] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue with a reference register file.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        wb_stall;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pending;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [31:0] rf [32];
    logic [36:0] wlog [$];

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wb_stall(wb_stall),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    // Reference register file: $0 hard-wired to zero, commit on rising edge.
    always @(posedge clk) begin
        if (we3) begin
            pulses++;
            wlog.push_back({wa3, wd3});
            if (wa3 != 5'd0)
                rf[wa3] <= wd3;
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        logic [36:0] e;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; wb_stall = 1'b0;

        // Reset and idle
        #2;
        chk("rst_we3", we3, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("idle_we3", we3, 0);
        chk("idle_count", count, 0);
        chk("idle_ready", req_ready, 1);
        chk("idle_pending", pending, 0);

        // Single request, minimum latency
        req_valid = 1'b1; req_addr = 5'd5; req_data = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        #1;
        chk("single_we3", we3, 1);
        chk("single_wa3", wa3, 5);
        chk("single_wd3", wd3, 32'hDEADBEEF);
        chk("single_pending", pending, 32'h20);
        chk("single_count", count, 1);
        tick();
        chk("single_rf5", rf_read(5'd5), 32'hDEADBEEF);
        chk("single_pending_clr", pending, 0);
        chk("single_we3_off", we3, 0);

        // Fill under stall, attempt push when full, then drain
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_addr = 5'(i); req_data = 32'(i * 32'h11);
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("full_count", count, 4);
        chk("full_ready", req_ready, 0);
        chk("full_pending", pending, 32'h1E);
        chk("full_we3", we3, 0);
        req_valid = 1'b1; req_addr = 5'd9; req_data = 32'h99;
        tick();
        req_valid = 1'b0;
        #1;
        chk("full_nopush_count", count, 4);
        chk("full_nopush_pending", pending, 32'h1E);
        wlog.delete();
        wb_stall = 1'b0;
        #1;
        chk("drain_we3", we3, 1);
        chk("drain_wa3", wa3, 1);
        tick(); tick(); tick(); tick();
        chk("drain_count", count, 0);
        chk("drain_len", wlog.size(), 4);
        for (int i = 1; i <= 4; i++) begin
            e = (wlog.size() > 0) ? wlog.pop_front() : 37'h0;
            chk("drain_order", e, {5'(i), 32'(i * 32'h11)});
        end
        chk("drain_rf4", rf_read(5'd4), 32'h44);

        // Write to $0 is accepted but dropped
        p0 = pulses;
        req_valid = 1'b1; req_addr = 5'd0; req_data = 32'hFFFFFFFF;
        #1;
        chk("zero_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("zero_count", count, 0);
        chk("zero_we3", we3, 0);
        tick();
        chk("zero_pulses", pulses, p0);
        chk("zero_rf0", rf_read(5'd0), 0);

        // Same register twice: last write wins, pending held until second pop
        wlog.delete();
        wb_stall = 1'b1;
        req_valid = 1'b1; req_addr = 5'd7; req_data = 32'hA;
        tick();
        req_data = 32'hB;
        tick();
        req_valid = 1'b0;
        #1;
        chk("raw_count", count, 2);
        chk("raw_pending", pending, 32'h80);
        wb_stall = 1'b0;
        tick();
        chk("raw_pending_mid", pending, 32'h80);
        chk("raw_wd3_mid", wd3, 32'hB);
        chk("raw_rf7_mid", rf_read(5'd7), 32'hA);
        tick();
        chk("raw_pending_end", pending, 0);
        chk("raw_rf7", rf_read(5'd7), 32'hB);
        chk("raw_len", wlog.size(), 2);

        // Streaming: one push and one pop per cycle, pointers wrap
        wlog.delete();
        req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req_addr = 5'(8 + (k % 16)); req_data = 32'hC000_0000 + 32'(k);
            tick();
            chk("stream_count", count, 1);
        end
        req_valid = 1'b0;
        tick();
        chk("stream_empty", count, 0);
        chk("stream_len", wlog.size(), 20);
        for (int k = 0; k < 20; k++) begin
            e = (wlog.size() > 0) ? wlog.pop_front() : 37'h0;
            chk("stream_order", e, {5'(8 + (k % 16)), 32'hC000_0000 + 32'(k)});
        end
        for (int k = 4; k < 20; k++)
            chk("stream_rf", rf_read(5'(8 + (k % 16))), 32'hC000_0000 + 32'(k));

        // Reset in the middle of a drain
        wb_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_addr = 5'(i); req_data = 32'h100 + 32'(i);
            tick();
        end
        req_valid = 1'b0;
        wb_stall = 1'b0;
        tick();
        chk("mid_count", count, 2);
        chk("mid_we3", we3, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we3", we3, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_ready", req_ready, 1);
        p0 = pulses;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("mid_rst_pulses", pulses, p0);
        chk("mid_rst_count2", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
